// File: rtl/filter_ctrl_5x5_if.sv
// Pixel-in valid/ready handshake plus the drive bus toward the 5x5 filter.
// The slave modport is the control stage and the master modport is the pixel source.
interface filter_ctrl_5x5_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 11
) ();
   logic                  i_vld;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] o_x;
   logic                  o_en;
   logic [1:0]            o_sel_ln;
   logic [1:0]            o_sel_px;
   logic [ADDR_WIDTH-1:0] o_addr_ln;
   logic [ADDR_WIDTH-1:0] o_addr_px;
   logic                  o_y_vld;

   modport master (
      output i_vld, i_data,
      input  o_ready, o_x, o_en, o_sel_ln, o_sel_px, o_addr_ln, o_addr_px, o_y_vld
   );

   modport slave (
      input  i_vld, i_data,
      output o_ready, o_x, o_en, o_sel_ln, o_sel_px, o_addr_ln, o_addr_px, o_y_vld
   );
endinterface

// File: rtl/filter_ctrl_5x5.sv
// Raster-scan control ahead of the 5x5 filter: filter drive one cycle after each transfer, o_y_vld PIPE_LAT later.
// Input stalls via o_ready (high only in FILL/RUN); optional size check under FILTER_CTRL_SIZE_CHECK_EN.
module filter_ctrl_5x5 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_WIDTH  = 1920,
   parameter int PIPE_LAT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_width,
   input  logic [ADDR_WIDTH-1:0] i_height,
   filter_ctrl_5x5_if.slave      io_bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam int                    CW          = $clog2(PIPE_LAT + 1);
   localparam logic [ADDR_WIDTH-1:0] LP_MAX_M1   = ADDR_WIDTH'(MAX_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LP_FILL_END = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] LP_WIN_MIN  = ADDR_WIDTH'(4);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_wm1;
   logic [ADDR_WIDTH-1:0] r_hm1;
   logic [ADDR_WIDTH-1:0] r_col;
   logic [ADDR_WIDTH-1:0] r_row;
   logic [1:0]            r_sel_ln;
   logic [CW-1:0]         r_flush_cnt;
   logic                  r_win;
   logic [PIPE_LAT-1:0]   r_yv_sh;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] r_x;
   logic [1:0]            r_sel_ln_o;
   logic [1:0]            r_sel_px;
   logic [ADDR_WIDTH-1:0] r_addr_ln;
   logic [ADDR_WIDTH-1:0] r_addr_px;
   logic                  w_ready;
   logic                  w_xfer;
   logic                  w_col_end;
   logic                  w_row_end;
   logic                  w_last;
   logic                  w_size_ok;
   logic                  w_accept;

   assign w_xfer    = io_bus.i_vld & w_ready;
   // The MAX_WIDTH clamp keeps the counters in range even for an unchecked bad size.
   assign w_col_end = (r_col == r_wm1) | (r_col == LP_MAX_M1);
   assign w_row_end = (r_row == r_hm1) | (r_row == LP_MAX_M1);
   assign w_last    = w_col_end & w_row_end;
   assign w_accept  = i_start & (r_state == S_IDLE) & w_size_ok;

`ifdef FILTER_CTRL_SIZE_CHECK_EN
   localparam logic [ADDR_WIDTH-1:0] LP_MIN_SIZE = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] LP_MAX_SIZE = ADDR_WIDTH'(MAX_WIDTH);
   logic r_err;

   assign w_size_ok = (i_width >= LP_MIN_SIZE) & (i_height >= LP_MIN_SIZE) &
                      (i_width <= LP_MAX_SIZE) & (i_height <= LP_MAX_SIZE);

   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= i_start & (r_state == S_IDLE) & ~w_size_ok;
   end

   assign o_err = r_err;
`else
   assign w_size_ok = 1'b1;
   assign o_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_FILL;
         S_FILL: begin
            if (w_xfer & w_last)
               w_next = S_FLUSH;
            else if (w_xfer & w_col_end & (r_row == LP_FILL_END))
               w_next = S_RUN;
         end
         S_RUN:   if (w_xfer & w_last) w_next = S_FLUSH;
         S_FLUSH: if (r_flush_cnt == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      o_busy  = 1'b1;
      o_done  = 1'b0;
      case (r_state)
         S_IDLE:  o_busy  = 1'b0;
         S_FILL:  w_ready = 1'b1;
         S_RUN:   w_ready = 1'b1;
         S_DONE:  o_done  = 1'b1;
         default: o_busy  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wm1       <= '0;
         r_hm1       <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_sel_ln    <= '0;
         r_flush_cnt <= '0;
         r_win       <= 1'b0;
         r_yv_sh     <= '0;
         r_en        <= 1'b0;
         r_x         <= '0;
         r_sel_ln_o  <= '0;
         r_sel_px    <= '0;
         r_addr_ln   <= '0;
         r_addr_px   <= '0;
      end else begin
         r_en    <= w_xfer;
         r_win   <= w_xfer & (r_row >= LP_WIN_MIN) & (r_col >= LP_WIN_MIN);
         r_yv_sh <= PIPE_LAT'({r_yv_sh, r_win});

         // Loaded while outside FLUSH so the count is ready on entry.
         if (r_state != S_FLUSH)
            r_flush_cnt <= CW'(PIPE_LAT);
         else if (r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - 1'b1;

         if (w_accept) begin
            r_wm1    <= i_width - 1'b1;
            r_hm1    <= i_height - 1'b1;
            r_col    <= '0;
            r_row    <= '0;
            r_sel_ln <= '0;
         end else if (w_xfer) begin
            r_x        <= io_bus.i_data;
            r_sel_ln_o <= r_sel_ln;
            r_sel_px   <= r_col[1:0];
            r_addr_ln  <= r_col;
            r_addr_px  <= r_row;
            if (w_col_end) begin
               r_col    <= '0;
               r_row    <= w_last ? '0 : r_row + 1'b1;
               r_sel_ln <= r_sel_ln + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign io_bus.o_ready   = w_ready;
   assign io_bus.o_en      = r_en;
   assign io_bus.o_x       = r_x;
   assign io_bus.o_sel_ln  = r_sel_ln_o;
   assign io_bus.o_sel_px  = r_sel_px;
   assign io_bus.o_addr_ln = r_addr_ln;
   assign io_bus.o_addr_px = r_addr_px;
   assign io_bus.o_y_vld   = r_yv_sh[PIPE_LAT-1];
endmodule

// File: tb/tb_filter_ctrl_5x5.sv
// Directed bench for filter_ctrl_5x5: frames of several sizes, stalls, ignored starts, mid-frame reset.
// A negedge monitor checks every filter-drive beat against the raster position the bench expects.
module tb_filter_ctrl_5x5;
   localparam int DW = 8;
   localparam int AW = 11;
   localparam int PL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_width = '0;
   logic [AW-1:0] i_height = '0;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   filter_ctrl_5x5_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   filter_ctrl_5x5 #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WIDTH(1920), .PIPE_LAT(PL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_width  (i_width),
      .i_height (i_height),
      .io_bus   (bus),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int fw = 8;
   int exp_k = 0;
   int en_cnt = 0, y_cnt = 0, done_cnt = 0, err_cnt = 0;
   int en44_cyc = -1, first_y_cyc = -1, last_en_cyc = -1, done_cyc = -1;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int k);
      return 8'((k * 7 + 3) & 255);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_en) begin : mon_pix
            int r;
            int c;
            logic [33:0] ev;
            r  = exp_k / fw;
            c  = exp_k % fw;
            ev = {2'(r % 4), 2'(c % 4), 11'(c), 11'(r), pix(exp_k)};
            chk_eq("pix_beat", {bus.o_sel_ln, bus.o_sel_px, bus.o_addr_ln, bus.o_addr_px, bus.o_x}, ev);
            if (r == 4 && c == 4) en44_cyc = cyc;
            last_en_cyc = cyc;
            en_cnt++;
            exp_k++;
         end
         if (bus.o_y_vld) begin
            y_cnt++;
            if (y_cnt == 1) first_y_cyc = cyc;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (o_err) err_cnt++;
      end
   end

   task automatic clear_stats(input int w);
      fw = w; exp_k = 0; en_cnt = 0; y_cnt = 0; done_cnt = 0;
      en44_cyc = -1; first_y_cyc = -1; last_en_cyc = -1; done_cyc = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int w, input int h);
      i_start = 1'b1; i_width = AW'(w); i_height = AW'(h);
      step();
      i_start = 1'b0;
   endtask

   // Offers pixels 0..stop_k-1; a W=16 start is pulsed alongside pixel start_k.
   task automatic feed(input int n, input bit toggle, input int start_k, input int stop_k);
      int k = 0;
      int g = 0;
      bit x;
      while (k < stop_k && g < 4 * n + 50) begin
         bus.i_vld  = toggle ? ~g[0] : 1'b1;
         bus.i_data = pix(k);
         i_start    = (k == start_k) && bus.i_vld;
         if (i_start) begin
            i_width  = AW'(16);
            i_height = AW'(6);
         end
         x = bus.i_vld & bus.o_ready;
         step();
         if (x) k++;
         g++;
      end
      bus.i_vld = 1'b0;
      i_start   = 1'b0;
      chk_eq("feed_budget", k, stop_k);
   endtask

   task automatic finish_frame(input string nm, input int exp_en, input int exp_y);
      chk_eq({nm, "_ready_drop"}, bus.o_ready, 0);
      for (int i = 0; i < 40 && done_cnt == 0; i++) step();
      repeat (3) step();
      chk_eq({nm, "_en_cnt"}, en_cnt, exp_en);
      chk_eq({nm, "_y_cnt"}, y_cnt, exp_y);
      chk_eq({nm, "_done_cnt"}, done_cnt, 1);
      chk_eq({nm, "_y_lat"}, first_y_cyc - en44_cyc, PL);
      chk_eq({nm, "_done_lat"}, done_cyc - last_en_cyc, PL + 1);
      chk_eq({nm, "_idle_busy"}, o_busy, 0);
   endtask

   initial begin
      bus.i_vld  = 1'b0;
      bus.i_data = '0;
      repeat (3) step();
      chk_eq("rst_busy", o_busy, 0);
      chk_eq("rst_done", o_done, 0);
      chk_eq("rst_err", o_err, 0);
      chk_eq("rst_ready", bus.o_ready, 0);
      chk_eq("rst_en", bus.o_en, 0);
      chk_eq("rst_y_vld", bus.o_y_vld, 0);
      chk_eq("rst_addr", {bus.o_addr_ln, bus.o_addr_px, bus.o_sel_ln, bus.o_sel_px, bus.o_x}, 0);
      rst = 1'b0;
      step();

      // 8x6 continuous
      clear_stats(8);
      start_frame(8, 6);
      chk_eq("a_busy", o_busy, 1);
      chk_eq("a_ready", bus.o_ready, 1);
      feed(48, 1'b0, -1, 48);
      finish_frame("a", 48, 8);

      // 8x6 with i_vld toggling
      clear_stats(8);
      start_frame(8, 6);
      feed(48, 1'b1, -1, 48);
      finish_frame("b", 48, 8);

      // widest frame, minimum useful height
      clear_stats(1920);
      start_frame(1920, 5);
      feed(9600, 1'b0, -1, 9600);
      finish_frame("c", 9600, 1916);

      // W=16 start pulsed mid-frame is ignored
      clear_stats(8);
      start_frame(8, 6);
      feed(48, 1'b0, 20, 48);
      finish_frame("d", 48, 8);

      // start coincident with the last transfer is ignored
      clear_stats(8);
      start_frame(8, 6);
      feed(48, 1'b0, 47, 48);
      finish_frame("e", 48, 8);
      chk_eq("e_no_restart_ready", bus.o_ready, 0);

      // reset during row 4 with window beats in flight
      clear_stats(8);
      start_frame(8, 6);
      feed(48, 1'b0, -1, 38);
      rst = 1'b1;
      step();
      chk_eq("mrst_busy", o_busy, 0);
      chk_eq("mrst_y_vld", bus.o_y_vld, 0);
      chk_eq("mrst_ready", bus.o_ready, 0);
      chk_eq("mrst_en", bus.o_en, 0);
      rst = 1'b0;
      repeat (10) step();
      chk_eq("mrst_no_y", y_cnt, 0);
      chk_eq("mrst_no_done", done_cnt, 0);
      clear_stats(8);
      start_frame(8, 6);
      feed(48, 1'b0, -1, 48);
      finish_frame("f", 48, 8);

`ifdef FILTER_CTRL_SIZE_CHECK_EN
      i_start = 1'b1; i_width = AW'(4); i_height = AW'(6);
      step();
      i_start = 1'b0;
      chk_eq("szerr_err", o_err, 1);
      chk_eq("szerr_busy", o_busy, 0);
      chk_eq("szerr_ready", bus.o_ready, 0);
      step();
      chk_eq("szerr_pulse_end", o_err, 0);
      chk_eq("szerr_busy2", o_busy, 0);
`else
      chk_eq("err_never", err_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
      $fatal(1, "time limit");
   end
endmodule
